// File: rtl/exe_muldiv_unit.sv
// EXE-stage iterative multiply/divide unit: 1 bit per cycle shift-add multiplier and
// restoring divider writing HI/LO, with pipeline stall and flush handling.
module exe_muldiv_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [5:0]  CMD_MULT  = 6'd24,
  parameter logic [5:0]  CMD_MULTU = 6'd25,
  parameter logic [5:0]  CMD_DIV   = 6'd26,
  parameter logic [5:0]  CMD_DIVU  = 6'd27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Flush,
  input  logic [5:0]       EXE_CMD,
  input  logic [WIDTH-1:0] Val1,
  input  logic [WIDTH-1:0] Val2,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] orig_a_q;
  logic             is_div_q;
  logic             neg_q_q;
  logic             neg_r_q;

  // Command decode and operand conditioning
  logic             cmd_mult, cmd_multu, cmd_div, cmd_divu;
  logic             valid_cmd, cmd_signed, cmd_is_div;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             start_c;
  logic             last_c;

  always_comb begin
    cmd_mult   = (EXE_CMD == CMD_MULT);
    cmd_multu  = (EXE_CMD == CMD_MULTU);
    cmd_div    = (EXE_CMD == CMD_DIV);
    cmd_divu   = (EXE_CMD == CMD_DIVU);
    valid_cmd  = cmd_mult | cmd_multu | cmd_div | cmd_divu;
    cmd_signed = cmd_mult | cmd_div;
    cmd_is_div = cmd_div | cmd_divu;
    a_neg      = cmd_signed & Val1[WIDTH-1];
    b_neg      = cmd_signed & Val2[WIDTH-1];
    a_mag      = a_neg ? -Val1 : Val1;
    b_mag      = b_neg ? -Val2 : Val2;
    // rst gates the start so Stall drops the moment reset asserts
    start_c    = (state_q == S_IDLE) & valid_cmd & ~Flush & ~rst;
    last_c     = (count_q == LAST_CNT);
  end

  assign Stall = (state_q == S_RUN) | start_c;

  // One iteration of either datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    // Remainder before the shift is below the divisor, so the difference fits WIDTH bits
    div_diff  = div_shift[WIDTH-1:0] - opb_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero handling of the final iteration
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod_raw = {step_hi, step_lo};
    prod_fix = neg_q_q ? -prod_raw : prod_raw;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (opb_q == '0) begin
        res_hi = orig_a_q;
        res_lo = '1;
      end else begin
        res_hi = neg_r_q ? -step_hi : step_hi;
        res_lo = neg_q_q ? -step_lo : step_lo;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_c) state_d = S_RUN;
      S_RUN: begin
        if (Flush)       state_d = S_IDLE;
        else if (last_c) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, result registers and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      orig_a_q <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (start_c) begin
        count_q  <= '0;
        acc_hi_q <= '0;
        acc_lo_q <= a_mag;
        opb_q    <= b_mag;
        orig_a_q <= Val1;
        is_div_q <= cmd_is_div;
        neg_q_q  <= a_neg ^ b_neg;
        neg_r_q  <= cmd_is_div & a_neg;
      end else if ((state_q == S_RUN) && !Flush) begin
        count_q  <= count_q + CW'(1);
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
        if (last_c) begin
          HI   <= res_hi;
          LO   <= res_lo;
          Done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed self-checking bench for exe_muldiv_unit: latency, stall window, results,
// divide corner cases, flush abort and asynchronous reset.
module tb_exe_muldiv_unit;

  localparam logic [5:0] MULT  = 6'd24;
  localparam logic [5:0] MULTU = 6'd25;
  localparam logic [5:0] DIV   = 6'd26;
  localparam logic [5:0] DIVU  = 6'd27;
  localparam logic [5:0] NOP   = 6'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        Flush;
  logic [5:0]  EXE_CMD;
  logic [31:0] Val1, Val2;
  logic        Stall, Done;
  logic [31:0] HI, LO;

  int n_total = 0;
  int n_pass  = 0;

  exe_muldiv_unit dut (
    .clk     (clk),
    .rst     (rst),
    .Flush   (Flush),
    .EXE_CMD (EXE_CMD),
    .Val1    (Val1),
    .Val2    (Val2),
    .Stall   (Stall),
    .Done    (Done),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op, count its stall window and check the result in the DONE cycle
  task automatic run_op(input string tag, input logic [5:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cnt;
    step();
    EXE_CMD = cmd;
    Val1    = a;
    Val2    = b;
    #1;
    chk({tag, "_stall0"}, 32'(Stall), 32'd1);
    chk({tag, "_done0"}, 32'(Done), 32'd0);
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!Stall) break;
      cnt++;
    end
    chk({tag, "_stall_cycles"}, 32'(cnt), 32'd33);
    chk({tag, "_done"}, 32'(Done), 32'd1);
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    rst     = 1'b1;
    Flush   = 1'b0;
    EXE_CMD = 6'd0;
    Val1    = '0;
    Val2    = '0;
    step();
    step();
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    rst = 1'b0;

    run_op("mult_7_m3", MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("multu_b2b", MULTU, 32'd2, 32'd3, 32'h0, 32'h6);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'h2, 32'hE);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu_by0", DIVU, 32'd5, 32'd0, 32'h5, 32'hFFFF_FFFF);

    // Flush during RUN cycle 10 aborts the multiply
    step();
    EXE_CMD = MULT;
    Val1    = 32'd7;
    Val2    = 32'hFFFF_FFFD;
    for (int k = 0; k < 10; k++) step();
    Flush = 1'b1;
    #1;
    chk("flush_stall_same", 32'(Stall), 32'd1);
    step();
    Flush   = 1'b0;
    EXE_CMD = NOP;
    #1;
    chk("flush_stall_next", 32'(Stall), 32'd0);
    chk("flush_done_next", 32'(Done), 32'd0);
    for (int k = 0; k < 25; k++) step();
    chk("flush_done_late", 32'(Done), 32'd0);
    chk("flush_hi", HI, 32'h5);
    chk("flush_lo", LO, 32'hFFFF_FFFF);

    // Flush in IDLE prevents a start
    EXE_CMD = MULTU;
    Flush   = 1'b1;
    #1;
    chk("idle_flush_stall", 32'(Stall), 32'd0);
    step();
    Flush   = 1'b0;
    EXE_CMD = NOP;
    #1;
    chk("idle_flush_nostart", 32'(Stall), 32'd0);

    // Asynchronous reset in the middle of a divide
    step();
    EXE_CMD = DIV;
    Val1    = 32'hFFFF_FFF9;
    Val2    = 32'd2;
    for (int k = 0; k < 5; k++) step();
    #1;
    chk("mid_div_stall", 32'(Stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", 32'(Stall), 32'd0);
    chk("midrst_done", 32'(Done), 32'd0);
    chk("midrst_hi", HI, 32'h0);
    chk("midrst_lo", LO, 32'h0);
    step();
    rst     = 1'b0;
    EXE_CMD = NOP;
    #1;
    chk("nop_stall", 32'(Stall), 32'd0);
    for (int k = 0; k < 40; k++) step();
    chk("nop_stall_late", 32'(Stall), 32'd0);
    chk("nop_done", 32'(Done), 32'd0);
    chk("nop_lo", LO, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
